// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Groups the requester handshake, the byte-transmitter link and the packet
// status signals of uart_tx_arbiter into one bundle.
//   master : the environment (requesters + transmitter) side
//   slave  : the arbiter side
// Signals:
//   req_valid / req_cmd / req_ready  requester command handshake
//   tx_data / tx_en / tx_done        byte transmitter link
//   pkt_done / pkt_id / busy         packet status
//   pkt_err                          timeout abort pulse (UART_ARB_TIMEOUT_EN only)
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int CMD_PKT_LEN = 16,
  parameter int NUM_REQ     = 4
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*CMD_PKT_LEN-1:0] req_cmd;
  logic [NUM_REQ-1:0]             req_ready;
  logic [DATA_WIDTH-1:0]          tx_data;
  logic                           tx_en;
  logic                           tx_done;
  logic                           pkt_done;
  logic [ID_W-1:0]                pkt_id;
  logic                           busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic                           pkt_err;

  modport master (
    output req_valid, req_cmd, tx_done,
    input  req_ready, tx_data, tx_en, pkt_done, pkt_id, busy, pkt_err
  );
  modport slave (
    input  req_valid, req_cmd, tx_done,
    output req_ready, tx_data, tx_en, pkt_done, pkt_id, busy, pkt_err
  );
`else
  modport master (
    output req_valid, req_cmd, tx_done,
    input  req_ready, tx_data, tx_en, pkt_done, pkt_id, busy
  );
  modport slave (
    input  req_valid, req_cmd, tx_done,
    output req_ready, tx_data, tx_en, pkt_done, pkt_id, busy
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that accepts one command packet at a time from NUM_REQ
// requesters and sends it to a byte UART transmitter: the high byte always,
// the low byte only for write commands (cmd MSB = 1).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_arbiter_if.slave (requester handshake, tx link, status)
// Build option: define UART_ARB_TIMEOUT_EN to abort a byte that sees no
// tx_done edge within TIMEOUT_CYCLES clocks and report it on bus.pkt_err.
//
// state   | meaning
// IDLE    | waiting for a requester; req_ready driven to the RR winner
// SEND_HI | tx_en strobe with the command high byte
// WAIT_HI | waiting for tx_done edge after the high byte
// SEND_LO | tx_en strobe with the command low byte (writes only)
// WAIT_LO | waiting for tx_done edge after the low byte
module uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int CMD_PKT_LEN    = 16,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_HI = 3'd1,
    WAIT_HI = 3'd2,
    SEND_LO = 3'd3,
    WAIT_LO = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CMD_PKT_LEN-1:0] cmd_q, cmd_d;
  logic [ID_W-1:0]        pkt_id_q, pkt_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   tx_done_prev_q;
  logic                   edge_q, edge_d;

  logic                   grant_found;
  logic [ID_W-1:0]        grant_idx;
  logic [ID_W-1:0]        cand;
  logic [NUM_REQ-1:0]     req_ready;
  logic [DATA_WIDTH-1:0]  tx_data;
  logic                   tx_en;
  logic                   pkt_done;
  logic                   in_wait;
  logic                   timeout_hit;

  assign in_wait = (state_q == WAIT_HI) || (state_q == WAIT_LO);

  // Rises seen outside the wait states are dropped here so a stray tx_done
  // cannot complete a byte that has not been sent yet.
  assign edge_d = bus.tx_done && !tx_done_prev_q && in_wait;

  // Round-robin search from rr_ptr_q; NUM_REQ is a power of two so the
  // ID_W-bit sum wraps naturally.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr_q + ID_W'(k);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    pkt_id_d = pkt_id_q;
    rr_ptr_d = rr_ptr_q;
    pkt_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          cmd_d    = bus.req_cmd[grant_idx*CMD_PKT_LEN +: CMD_PKT_LEN];
          pkt_id_d = grant_idx;
          rr_ptr_d = grant_idx + ID_W'(1);
          state_d  = SEND_HI;
        end
      end
      SEND_HI: state_d = WAIT_HI;
      WAIT_HI: begin
        if (edge_q) begin
          if (cmd_q[CMD_PKT_LEN-1]) begin
            state_d = SEND_LO;
          end else begin
            state_d  = IDLE;
            pkt_done = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      SEND_LO: state_d = WAIT_LO;
      WAIT_LO: begin
        if (edge_q) begin
          state_d  = IDLE;
          pkt_done = 1'b1;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_en   = (state_q == SEND_HI) || (state_q == SEND_LO);
    tx_data = '0;
    case (state_q)
      SEND_HI, WAIT_HI: tx_data = DATA_WIDTH'(cmd_q[CMD_PKT_LEN-1:DATA_WIDTH]);
      SEND_LO, WAIT_LO: tx_data = cmd_q[DATA_WIDTH-1:0];
      default:          tx_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cmd_q          <= '0;
      pkt_id_q       <= '0;
      rr_ptr_q       <= '0;
      tx_done_prev_q <= 1'b0;
      edge_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      pkt_id_q       <= pkt_id_d;
      rr_ptr_q       <= rr_ptr_d;
      tx_done_prev_q <= bus.tx_done;
      edge_q         <= edge_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Down-counter loaded while sending so the first wait cycle holds
  // TIMEOUT_CYCLES-1; terminal count 0 marks the last allowed wait cycle.
  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (state_q == SEND_HI || state_q == SEND_LO) tmr_d = TMR_LOAD;
    else if (in_wait && tmr_q != '0)              tmr_d = tmr_q - TMR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end

  assign timeout_hit = in_wait && (tmr_q == '0);
  assign bus.pkt_err = timeout_hit && !edge_q;
`else
  // Timeout depth has no effect when the abort feature is not built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  assign bus.req_ready = req_ready;
  assign bus.tx_data   = tx_data;
  assign bus.tx_en     = tx_en;
  assign bus.pkt_done  = pkt_done;
  assign bus.pkt_id    = pkt_id_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
